// File: rtl/output_port.sv
// output_port: buffered CPU output port. OUT writes land in a small FIFO and
// a transmit FSM moves each entry to the external pins with a four-phase
// strobe/acknowledge handshake. The pins keep the last transferred value.
module output_port #(
  parameter int DataSize = 4,
  parameter int OutSize  = 2,
  parameter int Depth    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DataSize-1:0] OUTD,
  input  logic                OUTWR,
  output logic                FULL,
  output logic                EMPTY,
  output logic                OVF,
  output logic [OutSize-1:0]  OUTPUT,
  output logic                OSTB,
  input  logic                OACK
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [CW-1:0]      cnt_q;
  logic [OutSize-1:0] mem [Depth];
  logic               push;
  logic               pop;

  // Upper CPU data bits are deliberately dropped; only the pin width is stored.
  logic unused_outd;
  assign unused_outd = ^OUTD;

  // Flags come straight from the registered occupancy count.
  assign FULL  = (cnt_q == CW'(Depth));
  assign EMPTY = (cnt_q == '0);

  // A write while full is lost, even if the FSM pops on the same edge.
  assign push = OUTWR & ~FULL;

  // Transmit FSM next state; the pop happens on the IDLE->STROBE edge.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!EMPTY) begin
          pop     = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (OACK) state_d = RELEASE;
      end
      RELEASE: begin
        if (!OACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, registered strobe and output pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      OSTB    <= 1'b0;
      OUTPUT  <= '0;
    end else begin
      state_q <= state_d;
      OSTB    <= (state_d == STROBE);
      if (pop) OUTPUT <= mem[rptr_q];
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wptr_q] <= OUTD[OutSize-1:0];
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF <= 1'b0;
    end else if (OUTWR && FULL) begin
      OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_port.sv
// tb_output_port: randomized and directed stimulus for output_port with a
// queue-based reference model and a strobe-driven scoreboard monitor.
module tb_output_port;

  localparam int DataSize = 4;
  localparam int OutSize  = 2;
  localparam int Depth    = 4;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic [DataSize-1:0] OUTD = '0;
  logic                OUTWR = 1'b0;
  logic                OACK = 1'b0;
  logic                FULL;
  logic                EMPTY;
  logic                OVF;
  logic [OutSize-1:0]  OUTPUT;
  logic                OSTB;

  output_port #(.DataSize(DataSize), .OutSize(OutSize), .Depth(Depth)) dut (
    .CLK(CLK), .RST(RST), .OUTD(OUTD), .OUTWR(OUTWR),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF),
    .OUTPUT(OUTPUT), .OSTB(OSTB), .OACK(OACK)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: the FIFO is a plain queue; the port is either idle,
  // showing a word waiting for ack, or waiting for ack to drop.
  int  q[$];
  int  sb[$];
  bit  m_ovf = 0;
  int  m_out = 0;
  int  m_phase = 0;   // 0 idle, 1 strobing, 2 waiting for ack release

  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
      sb.delete();
      m_ovf = 0;
      m_out = 0;
      m_phase = 0;
    end else begin
      bit was_full;
      was_full = (q.size() == Depth);
      if (m_phase == 0 && q.size() > 0) begin
        m_out = q.pop_front();
        m_phase = 1;
      end else if (m_phase == 1 && OACK) begin
        m_phase = 2;
      end else if (m_phase == 2 && !OACK) begin
        m_phase = 0;
      end
      if (OUTWR) begin
        if (was_full) m_ovf = 1;
        else begin
          q.push_back(int'(OUTD) % (1 << OutSize));
          sb.push_back(int'(OUTD) % (1 << OutSize));
        end
      end
    end
  end

  // Monitor: per-cycle flag comparison and in-order check of each new strobe.
  bit prev_ostb = 0;
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_output", int'(OUTPUT), m_out);
      chk("m_ostb",   int'(OSTB),   (m_phase == 1) ? 1 : 0);
      chk("m_full",   int'(FULL),   (q.size() == Depth) ? 1 : 0);
      chk("m_empty",  int'(EMPTY),  (q.size() == 0) ? 1 : 0);
      chk("m_ovf",    int'(OVF),    int'(m_ovf));
      if (OSTB && !prev_ostb) begin
        if (sb.size() == 0) fail_now("sb_underflow");
        else chk("strobe_data", int'(OUTPUT), sb.pop_front());
      end
    end
    prev_ostb = OSTB;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int d);
    OUTD = DataSize'(d);
    OUTWR = 1'b1;
    cyc();
    OUTWR = 1'b0;
  endtask

  task automatic handshake();
    int n;
    n = 0;
    while (!OSTB && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) begin
      fail_now("wait_ostb");
      return;
    end
    OACK = 1'b1;
    cyc();
    OACK = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset with write and ack both asserted.
    RST = 1'b1; OUTWR = 1'b1; OACK = 1'b1; OUTD = 4'hF;
    cyc(); cyc();
    RST = 1'b0; OUTWR = 1'b0; OACK = 1'b0;
    chk_en = 1'b1;
    chk("rst_output", int'(OUTPUT), 0);
    chk("rst_ostb",   int'(OSTB), 0);
    chk("rst_empty",  int'(EMPTY), 1);
    chk("rst_full",   int'(FULL), 0);
    chk("rst_ovf",    int'(OVF), 0);
    cyc();
    chk("rst_noentry_empty", int'(EMPTY), 1);
    chk("rst_noentry_ostb",  int'(OSTB), 0);

    // Single transfer of 4'b1110.
    wr(4'b1110);
    chk("single_empty_after_wr", int'(EMPTY), 0);
    cyc();
    chk("single_output", int'(OUTPUT), 2);
    chk("single_ostb",   int'(OSTB), 1);
    OACK = 1'b1;
    cyc();
    chk("single_ostb_drop", int'(OSTB), 0);
    OACK = 1'b0;
    cyc(); cyc();
    chk("single_output_hold", int'(OUTPUT), 2);
    chk("single_empty_end",   int'(EMPTY), 1);

    // Fill and overflow with ack held low.
    for (int v = 4; v <= 8; v++) wr(v);
    chk("fill_full",   int'(FULL), 1);
    chk("fill_ostb",   int'(OSTB), 1);
    chk("fill_output", int'(OUTPUT), 0);
    wr(9);
    chk("ovf_set",       int'(OVF), 1);
    chk("ovf_full_kept", int'(FULL), 1);
    for (int i = 0; i < 5; i++) handshake();
    cyc(); cyc();
    chk("drain_empty",   int'(EMPTY), 1);
    chk("drain_ovf",     int'(OVF), 1);
    chk("drain_sb_done", sb.size(), 0);

    // Wrap-around with random data.
    for (int i = 0; i < 10; i++) begin
      wr(int'($urandom_range(0, 15)));
      handshake();
    end
    cyc(); cyc();
    chk("wrap_empty",   int'(EMPTY), 1);
    chk("wrap_sb_done", sb.size(), 0);

    // Simultaneous push and pop while two entries are queued.
    wr(1); wr(2); wr(3);
    chk("pp_strobe_out", int'(OUTPUT), 1);
    OACK = 1'b1; cyc();
    OACK = 1'b0; cyc();
    OUTD = 4'b1100; OUTWR = 1'b1;
    cyc();
    OUTWR = 1'b0;
    chk("pp_output", int'(OUTPUT), 2);
    chk("pp_count2", q.size(), 2);
    chk("pp_not_full", int'(FULL), 0);
    for (int i = 0; i < 3; i++) handshake();
    cyc(); cyc();
    chk("pp_last_out", int'(OUTPUT), 0);
    chk("pp_empty",    int'(EMPTY), 1);

    // Random bursts mixing writes and handshakes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        OUTD = DataSize'($urandom_range(0, 15));
        OUTWR = 1'b1;
      end
      if (OSTB && $urandom_range(0, 2) == 0) OACK = 1'b1;
      else if (!OSTB) OACK = 1'b0;
      cyc();
      OUTWR = 1'b0;
    end
    OACK = 1'b0;
    cyc();
    while (!EMPTY || OSTB) begin
      if (!OSTB && EMPTY) break;
      handshake();
      if (n_total > 100000) break;
    end
    cyc(); cyc();
    chk("rand_empty", int'(EMPTY), 1);

    // Reset in the middle of a handshake with three entries queued.
    wr(5); wr(6); wr(7); wr(4);
    chk("mid_ostb_before", int'(OSTB), 1);
    RST = 1'b1; OACK = 1'b1;
    cyc();
    RST = 1'b0;
    chk("mid_ostb",   int'(OSTB), 0);
    chk("mid_output", int'(OUTPUT), 0);
    chk("mid_empty",  int'(EMPTY), 1);
    chk("mid_ovf",    int'(OVF), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_strobe", int'(OSTB), 0);
    end
    wr(4'b0111);
    cyc();
    chk("mid_new_ostb",   int'(OSTB), 1);
    chk("mid_new_output", int'(OUTPUT), 3);
    cyc();
    OACK = 1'b0;
    cyc(); cyc();
    chk("final_ostb",    int'(OSTB), 0);
    chk("final_sb_done", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "timeout");
  end

endmodule
